uart_tx_core: RTL and testbench
===============================

# uart_tx_core

UART transmit core: serialises bytes from the host register interface onto the `Tx_o` line. Frames are one start bit (0), 8 data bits LSB first, an optional parity bit, and one stop bit (1), with each bit timed by the baudrate generator's per-bit strobe. It is the transmit-side counterpart of the Rx core. A one-entry holding register lets the host queue the next byte while the current frame shifts out, so frames can be sent back-to-back.

## Interface
- Parameters: none (frame format fixed: 8 data bits, 1 stop bit)
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `BaudSig_i`  in  1  one-`clk` pulse per bit period from the baudrate generator
- `Data_i`  in  8  byte to transmit
- `Valid_i`  in  1  `Data_i` valid
- `Ready_o`  out  1  holding register empty; the byte is accepted when `Valid_i && Ready_o`
- `ParityEnable_i`  in  1  1 = insert a parity bit
- `ParityOdd_i`  in  1  1 = odd parity, 0 = even
- `Tx_o`  out  1  serial line, registered, idle high
- `Busy_o`  out  1  state ≠ INTERVAL or holding register full
- `Done_o`  out  1  one-cycle pulse when a stop bit completes
- `State_o`  out  5  one-hot FSM state
- `BitCounter_o`  out  4  number of data bits already sent in the current frame

## Operation
- States (one-hot): INTERVAL=5'b0_0001, STARTBIT=5'b0_0010, DATABITS=5'b0_0100, PARITYBIT=5'b0_1000, STOPBIT=5'b1_0000.
- Holding register:
  - Filled on accept.
  - `Ready_o = !hold_full`.
  - Emptied when it is transferred to the shift register.
  - Accept and transfer never occur in the same cycle.
- FSM transitions are evaluated only on cycles where `BaudSig_i`=1. Otherwise the state holds.
- INTERVAL → STARTBIT when `hold_full`. Same cycle:
  - Transfer the holding register to the shift register.
  - Latch `ParityEnable_i` and `ParityOdd_i` into the frame configuration.
  - Compute parity = ^data XOR odd.
- STARTBIT → DATABITS.
- DATABITS:
  - The counter increments on each strobe.
  - At count 7 with parity enabled → PARITYBIT. With parity disabled → STOPBIT.
  - The shift register shifts right on each strobe.
- PARITYBIT → STOPBIT.
- STOPBIT:
  - `Done_o` pulses.
  - If `hold_full` → STARTBIT, with the transfer as from INTERVAL (no idle gap).
  - Otherwise → INTERVAL.
- `Tx_o` by state: INTERVAL=1, STARTBIT=0, DATABITS=shift[0], PARITYBIT=latched parity, STOPBIT=1.
- Bit counter: 0 outside DATABITS. Range 0..7 within DATABITS; it never reaches 8.
- Host-input changes mid-frame: changing `ParityEnable_i` or `ParityOdd_i` affects only the next frame.
- Illegal (non-one-hot) state: next state is INTERVAL, `Tx_o`=1.

## Timing
- Reset values: `Tx_o`=1, `Ready_o`=1, `Busy_o`=0, `Done_o`=0, `State_o`=INTERVAL, `BitCounter_o`=0. The holding register is empty.
- Reset mid-frame: on the next edge the frame is aborted, the line returns high and any queued byte is discarded.
- `State_o`, `Tx_o` and `BitCounter_o` all update on the same edge, which follows the `BaudSig_i` cycle.
- Latency, idle core: accept at cycle t, then the start bit appears on the edge after the first strobe at or after t+1.
- Every bit lasts exactly one strobe interval.
- Frame length is 10 strobes without parity and 11 with parity.
- `Ready_o` rises on the edge after the transfer.
- `Done_o` is registered and is high during the cycle after the final strobe of STOPBIT.
- `Busy_o` is combinational from registered state.

## Configuration
- `UART_TX_TMR_EN` defined:
  - State register, bit counter and `Tx_o` register are each triplicated.
  - Every consumer sees a bitwise 2-of-3 majority vote, `(a&b)|(b&c)|(c&a)`.
  - All three copies are rewritten from the voted next value every cycle, which scrubs single upsets.
  - Copies are marked preserve.
- Undefined: single registers. Function and cycle timing are identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - The five state encodings.
  - `DATA_BITS=8`.
  - The majority-vote function.
  - Rx and Tx both import it.
- Natural sub-module: `uart_tx_shifter`, covering the holding register, shift register and parity latch.
- The FSM, counter and TMR logic stay in `uart_tx_core`.

## Test plan
- Idle, no valid: `Tx_o` stays 1 and `Busy_o`=0 over 100 strobes.
- Send 0xA5 with parity off: line sequence 0,1,0,1,0,0,1,0,1,1, one bit per strobe. `Done_o` pulses once. The core returns to INTERVAL.
- Send 0x03, even parity: parity bit 0, 11-bit frame. Odd parity: parity bit 1.
- Back-to-back: queue 0x55 while 0xAA is shifting. The next start bit follows the stop bit with no idle strobe, and `Ready_o` reasserts after the transfer.
- Assert `rst` in DATABITS at bit 4: next edge gives `Tx_o`=1, INTERVAL, `Ready_o`=1. The queued byte is never sent.
- `UART_TX_TMR_EN` build: force one copy of the state register to STOPBIT mid-frame. The frame completes unchanged and the copies reconverge on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and the
// majority-vote helper used by the triplicated register option.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STATE_W   = 5;
    localparam int CNT_W     = 4;
    localparam int VOTE_W    = STATE_W + CNT_W + 1;

    typedef enum logic [STATE_W-1:0] {
        ST_INTERVAL  = 5'b0_0001,
        ST_STARTBIT  = 5'b0_0010,
        ST_DATABITS  = 5'b0_0100,
        ST_PARITYBIT = 5'b0_1000,
        ST_STOPBIT   = 5'b1_0000
    } uart_state_e;

    // Bitwise 2-of-3 vote over a packed {state, counter, line} word.
    function automatic logic [VOTE_W-1:0] maj3(input logic [VOTE_W-1:0] a,
                                               input logic [VOTE_W-1:0] b,
                                               input logic [VOTE_W-1:0] c);
        return (a & b) | (b & c) | (c & a);
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Transmit datapath: one-entry holding register, output shift register and
// the parity/frame-format latch captured when a byte moves into the shifter.
module uart_tx_shifter
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    input  logic                 parity_enable,
    input  logic                 parity_odd,
    input  logic                 load,
    input  logic                 shift,
    output logic                 hold_full,
    output logic                 shift_lsb_next,
    output logic                 parity_bit,
    output logic                 frame_parity_en
);

    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 hold_full_q;
    logic                 parity_q;
    logic                 parity_en_q;
    logic                 accept;

    // Accept only into an empty holder and load only from a full one, so the
    // two can never coincide.
    assign accept = valid && !hold_full_q;

    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = hold_q;
        end else if (shift) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            parity_en_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            if (accept) begin
                hold_q      <= data;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
            if (load) begin
                parity_q    <= (^hold_q) ^ parity_odd;
                parity_en_q <= parity_enable;
            end
        end
    end

    assign hold_full       = hold_full_q;
    assign shift_lsb_next  = shift_d[0];
    assign parity_bit      = parity_q;
    assign frame_parity_en = parity_en_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: frame FSM, data-bit counter and registered line driver.
// Define UART_TX_TMR_EN to triplicate the state, counter and Tx_o registers.
//
// state     | meaning
// INTERVAL  | idle, line high, waiting for a queued byte
// STARTBIT  | driving the start bit (0)
// DATABITS  | shifting out 8 data bits, LSB first
// PARITYBIT | driving the parity bit latched for this frame
// STOPBIT   | driving the stop bit (1), may chain straight into the next frame
module uart_tx_core
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 BaudSig_i,
    input  logic [DATA_BITS-1:0] Data_i,
    input  logic                 Valid_i,
    output logic                 Ready_o,
    input  logic                 ParityEnable_i,
    input  logic                 ParityOdd_i,
    output logic                 Tx_o,
    output logic                 Busy_o,
    output logic                 Done_o,
    output logic [STATE_W-1:0]   State_o,
    output logic [CNT_W-1:0]     BitCounter_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    logic [STATE_W-1:0] state_cur;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_cur;
    logic [CNT_W-1:0]   cnt_d;
    logic               tx_cur;
    logic               tx_d;
    logic               done_q;
    logic               load;
    logic               shift;
    logic               hold_full;
    logic               shift_lsb_next;
    logic               parity_bit;
    logic               frame_parity_en;

    uart_tx_shifter u_shifter (
        .clk             (clk),
        .rst             (rst),
        .data            (Data_i),
        .valid           (Valid_i),
        .parity_enable   (ParityEnable_i),
        .parity_odd      (ParityOdd_i),
        .load            (load),
        .shift           (shift),
        .hold_full       (hold_full),
        .shift_lsb_next  (shift_lsb_next),
        .parity_bit      (parity_bit),
        .frame_parity_en (frame_parity_en)
    );

    always_comb begin
        state_d = state_cur;
        cnt_d   = '0;
        load    = 1'b0;
        shift   = 1'b0;
        tx_d    = 1'b1;

        case (state_cur)
            ST_INTERVAL: begin
                if (BaudSig_i && hold_full) begin
                    state_d = ST_STARTBIT;
                    load    = 1'b1;
                end
            end
            ST_STARTBIT: begin
                if (BaudSig_i) begin
                    state_d = ST_DATABITS;
                end
            end
            ST_DATABITS: begin
                cnt_d = cnt_cur;
                if (BaudSig_i) begin
                    shift = 1'b1;
                    // >= so an upset counter cannot run past the last bit
                    if (cnt_cur >= CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = frame_parity_en ? ST_PARITYBIT : ST_STOPBIT;
                    end else begin
                        cnt_d = cnt_cur + 4'd1;
                    end
                end
            end
            ST_PARITYBIT: begin
                if (BaudSig_i) begin
                    state_d = ST_STOPBIT;
                end
            end
            ST_STOPBIT: begin
                if (BaudSig_i) begin
                    if (hold_full) begin
                        state_d = ST_STARTBIT;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_INTERVAL;
                    end
                end
            end
            default: begin
                state_d = ST_INTERVAL;
            end
        endcase

        case (state_d)
            ST_STARTBIT:  tx_d = 1'b0;
            ST_DATABITS:  tx_d = shift_lsb_next;
            ST_PARITYBIT: tx_d = parity_bit;
            default:      tx_d = 1'b1;
        endcase
    end

`ifdef UART_TX_TMR_EN
    (* preserve *) logic [STATE_W-1:0] state_a;
    (* preserve *) logic [STATE_W-1:0] state_b;
    (* preserve *) logic [STATE_W-1:0] state_c;
    (* preserve *) logic [CNT_W-1:0]   cnt_a;
    (* preserve *) logic [CNT_W-1:0]   cnt_b;
    (* preserve *) logic [CNT_W-1:0]   cnt_c;
    (* preserve *) logic               tx_a;
    (* preserve *) logic               tx_b;
    (* preserve *) logic               tx_c;
    logic [VOTE_W-1:0] voted;

    assign voted = maj3({state_a, cnt_a, tx_a},
                        {state_b, cnt_b, tx_b},
                        {state_c, cnt_c, tx_c});
    assign {state_cur, cnt_cur, tx_cur} = voted;

    // All copies reload from the voted next value, scrubbing any single upset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_a <= ST_INTERVAL;
            state_b <= ST_INTERVAL;
            state_c <= ST_INTERVAL;
            cnt_a   <= '0;
            cnt_b   <= '0;
            cnt_c   <= '0;
            tx_a    <= 1'b1;
            tx_b    <= 1'b1;
            tx_c    <= 1'b1;
        end else begin
            state_a <= state_d;
            state_b <= state_d;
            state_c <= state_d;
            cnt_a   <= cnt_d;
            cnt_b   <= cnt_d;
            cnt_c   <= cnt_d;
            tx_a    <= tx_d;
            tx_b    <= tx_d;
            tx_c    <= tx_d;
        end
    end
`else
    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INTERVAL;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

    assign state_cur = state_q;
    assign cnt_cur   = cnt_q;
    assign tx_cur    = tx_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= BaudSig_i && (state_cur == ST_STOPBIT);
        end
    end

    assign Ready_o      = !hold_full;
    assign Busy_o       = (state_cur != ST_INTERVAL) || hold_full;
    assign Done_o       = done_q;
    assign Tx_o         = tx_cur;
    assign State_o      = state_cur;
    assign BitCounter_o = cnt_cur;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: table-driven frames through a line
// decoder/scoreboard plus hand sequences for back-to-back, reset and upsets.
module tb_uart_tx_core;
    import uart_pkg::*;

    localparam int BAUD_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BaudSig_i = 1'b0;
    logic [7:0] Data_i = 8'h00;
    logic       Valid_i = 1'b0;
    logic       ParityEnable_i = 1'b0;
    logic       ParityOdd_i = 1'b0;
    logic       Ready_o;
    logic       Tx_o;
    logic       Busy_o;
    logic       Done_o;
    logic [4:0] State_o;
    logic [3:0] BitCounter_o;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_core dut (
        .clk            (clk),
        .rst            (rst),
        .BaudSig_i      (BaudSig_i),
        .Data_i         (Data_i),
        .Valid_i        (Valid_i),
        .Ready_o        (Ready_o),
        .ParityEnable_i (ParityEnable_i),
        .ParityOdd_i    (ParityOdd_i),
        .Tx_o           (Tx_o),
        .Busy_o         (Busy_o),
        .Done_o         (Done_o),
        .State_o        (State_o),
        .BitCounter_o   (BitCounter_o)
    );

    always #5 clk = ~clk;

    int baud_cnt = 0;
    always @(negedge clk) begin
        if (baud_cnt == BAUD_DIV - 1) begin
            baud_cnt  = 0;
            BaudSig_i = 1'b1;
        end else begin
            baud_cnt  = baud_cnt + 1;
            BaudSig_i = 1'b0;
        end
    end

    int done_cnt = 0;
    always @(negedge clk) begin
        if (Done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       exp_par;
    } frame_t;

    frame_t sb_q[$];

    // Line decoder: samples Tx_o just after every strobe edge.
    bit         mon_en = 1'b0;
    int         mon_phase = 0;
    frame_t     cur;
    logic [7:0] rx_byte;
    int         strobe_idx = 0;
    int         last_stop_idx = -100;
    int         start_gap = 0;
    bit         expect_done = 1'b0;
    int         frames_seen = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (BaudSig_i) begin
                #1;
                strobe_idx++;
                if (expect_done) begin
                    check("done_after_stop", Done_o, 1);
                    expect_done = 1'b0;
                end
                if (!mon_en) begin
                    mon_phase = 0;
                end else if (mon_phase == 0) begin
                    if (Tx_o === 1'b0) begin
                        check("frame_expected", (sb_q.size() != 0), 1);
                        if (sb_q.size() != 0) begin
                            cur       = sb_q.pop_front();
                            start_gap = strobe_idx - last_stop_idx;
                            rx_byte   = 8'h00;
                            mon_phase = 1;
                        end
                    end
                end else if (mon_phase <= 8) begin
                    rx_byte[mon_phase-1] = Tx_o;
                    check("bit_counter", BitCounter_o, mon_phase - 1);
                    mon_phase = (mon_phase < 8) ? mon_phase + 1 : (cur.par_en ? 9 : 10);
                end else if (mon_phase == 9) begin
                    check("parity_bit", Tx_o, cur.exp_par);
                    mon_phase = 10;
                end else begin
                    check("stop_bit", Tx_o, 1);
                    check("rx_data", rx_byte, cur.data);
                    last_stop_idx = strobe_idx;
                    expect_done   = 1'b1;
                    frames_seen++;
                    mon_phase = 0;
                end
            end
        end
    end

    task automatic wait_strobe();
        int guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!BaudSig_i && guard < 100);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic po,
                        input logic ep, input bit push);
        int guard = 0;
        @(negedge clk);
        while (!Ready_o && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_send", Ready_o, 1);
        Data_i         = d;
        Valid_i        = 1'b1;
        ParityEnable_i = pe;
        ParityOdd_i    = po;
        @(posedge clk);
        if (push) sb_q.push_back('{d, pe, po, ep});
        @(negedge clk);
        Valid_i = 1'b0;
    endtask

    task automatic wait_state(input logic [4:0] s, input string name);
        int guard = 0;
        while (State_o !== s && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check(name, State_o, s);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((sb_q.size() != 0 || mon_phase != 0 || State_o !== ST_INTERVAL || Busy_o !== 1'b0)
               && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check(name, State_o, ST_INTERVAL);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t     vecs[8];
        logic [9:0] cap;
        int         bad;
        int         done_before;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{8'h6C, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_tx", Tx_o, 1);
        check("rst_ready", Ready_o, 1);
        check("rst_busy", Busy_o, 0);
        check("rst_done", Done_o, 0);
        check("rst_state", State_o, ST_INTERVAL);
        check("rst_bitcnt", BitCounter_o, 0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            wait_strobe();
            if (Tx_o !== 1'b1 || Busy_o !== 1'b0) bad++;
        end
        check("idle_100_strobes_bad", bad, 0);

        // Exact line sequence for 0xA5, no parity.
        done_before = done_cnt;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        bad = 0;
        do begin
            wait_strobe();
            bad++;
        end while (Tx_o !== 1'b0 && bad < 20);
        cap[0] = Tx_o;
        for (int i = 1; i < 10; i++) begin
            wait_strobe();
            cap[i] = Tx_o;
        end
        check("a5_line_seq", cap, 10'h34A);
        wait_idle("a5_idle");
        repeat (2) wait_strobe();
        check("a5_done_pulses", done_cnt - done_before, 1);

        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].par_en, vecs[i].par_odd, vecs[i].exp_par, 1'b1);
            wait_idle("table_idle");
        end

        // Back-to-back: queue 0x55 while 0xAA shifts.
        send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_state(ST_DATABITS, "b2b_first_databits");
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b_ready_low_queued", Ready_o, 0);
        check("b2b_busy", Busy_o, 1);
        wait_state(ST_STOPBIT, "b2b_stop");
        bad = 0;
        while (State_o === ST_STOPBIT && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        check("b2b_chain_state", State_o, ST_STARTBIT);
        check("b2b_ready_after_xfer", Ready_o, 1);
        wait_idle("b2b_idle");
        check("b2b_gap_strobes", start_gap, 1);

        // Parity inputs changed mid-frame must not affect the frame in flight.
        send(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_state(ST_DATABITS, "par_change_databits");
        ParityEnable_i = 1'b0;
        ParityOdd_i    = 1'b1;
        wait_idle("par_change_idle");

        // Reset in DATABITS at bit 4 with a byte queued.
        mon_en = 1'b0;
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_state(ST_DATABITS, "rst_mid_databits");
        send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        bad = 0;
        while (BitCounter_o !== 4'd4 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        check("rst_mid_bit4", BitCounter_o, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", Tx_o, 1);
        check("rst_mid_state", State_o, ST_INTERVAL);
        check("rst_mid_ready", Ready_o, 1);
        check("rst_mid_bitcnt", BitCounter_o, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            wait_strobe();
            if (Tx_o !== 1'b1 || State_o !== ST_INTERVAL) bad++;
        end
        check("rst_queued_discarded", bad, 0);
        mon_en = 1'b1;

`ifdef UART_TX_TMR_EN
        send(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_state(ST_DATABITS, "tmr_databits");
        @(negedge clk);
        force dut.state_b = ST_STOPBIT;
        @(posedge clk);
        #1;
        check("tmr_voted_state", State_o, ST_DATABITS);
        @(negedge clk);
        release dut.state_b;
        @(posedge clk);
        #1;
        check("tmr_reconverge", dut.state_b, dut.state_a);
        wait_idle("tmr_idle");
`endif

        repeat (3) wait_strobe();
        check("done_total", done_cnt, frames_seen + 1);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
